cdc_hs_tx: RTL and testbench
============================

// Module: cdc_hs_tx
// PURPOSE
//  Source-side transmitter of the 2-phase (toggle) req/ack CDC handshake for multi-bit words.
//  Accepts a word via valid/ready in the clk_src domain, holds it stable on tx_data, toggles tx_req.
//  Completes when the destination's toggled rx_ack is seen through an internal synchronizer.
//  Sits in the source domain; the destination receiver synchronizes tx_req with cdc_sync_dff.
// PARAMETERS
//  DATA_WIDTH       8  width of s_data / tx_data
//  NUM_SYNC_STAGES  2  synchronizer depth on rx_ack; legal range 2..4 (elaboration error otherwise)
// PORTS
//  clk_src   in   1           source clock; all logic on rising edge
//  rst_src   in   1           synchronous, active-high reset
//  s_valid   in   1           upstream word valid
//  s_ready   out  1           block can accept a word this cycle
//  s_data    in   DATA_WIDTH  upstream word
//  tx_data   out  DATA_WIDTH  word to destination domain; registered, stable while in flight
//  tx_req    out  1           request toggle to destination; registered
//  rx_ack    in   1           ack toggle from destination domain (asynchronous to clk_src)
//  busy      out  1           1 when state != IDLE
//  done      out  1           one-cycle pulse when a transfer completes
// BEHAVIOUR
//  Clock/reset: one clock, clk_src; reset rst_src is synchronous and active-high.
//  Reset: state=INIT, tx_req=0, tx_data=0, done=0, s_ready=0, busy=1, settle counter=0.
//  ack_sync = rx_ack through cdc_sync_dff (NUM_SYNC_STAGES); no reset on sync flops.
//  INIT: counter counts NUM_SYNC_STAGES edges; then -> IDLE only if ack_sync==tx_req (0);
//    stays in INIT while mismatched (destination not yet reset).
//  IDLE: s_ready=1. On s_valid&&s_ready: tx_data<=s_data, tx_req<=~tx_req, same edge; -> WAIT_ACK.
//  WAIT_ACK: s_ready=0. When ack_sync==tx_req: done=1 for one cycle, -> IDLE next edge.
//  tx_data/tx_req from flops only; no combinational path from s_* to tx_*.
//  tx_data never changes while ack_sync!=tx_req.
//  Latency: accept at edge N -> tx_req toggled after N. rx_ack toggled before edge k
//    -> ack_sync after edge k+NUM_SYNC_STAGES-1 -> IDLE/done after edge k+NUM_SYNC_STAGES.
//  Spurious rx_ack toggle in IDLE: ignored. Next accept toggles tx_req to mismatch again;
//    completion still waits for equality. Protocol violation; flagged by assertion only.
//  Reset mid-transfer: transfer is dropped, tx_req returns to 0, INIT gate re-applies.
//  s_data is ignored whenever s_ready=0; s_valid may drop without acceptance.
// CONFIGURATION
//  `CDC_TX_BUF_EN defined: one-entry holding buffer (buf_data, buf_valid).
//    WAIT_ACK: s_ready=~buf_valid; an accepted word goes into the buffer.
//    Completion with buf_valid: launch buf_data on the same edge (tx_data, toggle tx_req).
//      Stay in WAIT_ACK; buf_valid<=0; done pulses.
//    Completion with buffer empty and s_valid same edge: launch s_data directly; stay in WAIT_ACK.
//    Reset clears buf_valid.
//  Not defined: no buffer; s_ready=0 throughout WAIT_ACK and INIT.
// STRUCTURE
//  Shared header cdc_defs.vh: state localparams INIT=2'd0, IDLE=2'd1, WAIT_ACK=2'd2;
//    NUM_SYNC_STAGES range limits.
//  One sub-module: cdc_sync_dff (DATA_WIDTH=1, NUM_SYNC_STAGES) for rx_ack.
//  Bench model of the receiver uses a second cdc_sync_dff on tx_req.
// TESTING (NUM_SYNC_STAGES=2, DATA_WIDTH=8; bench drives rx_ack from the tx_req model)
//  1 Reset, rx_ack=0 -> s_ready=0 for 2 cycles after reset release, then s_ready=1, busy=0.
//  2 s_valid=1, s_data=8'hA5 at edge N -> tx_data=A5, tx_req=1 after N, s_ready=0.
//    rx_ack->1 before edge k -> done pulse and s_ready=1 after edge k+2.
//  3 Hold rx_ack=1 through reset -> block stays in INIT (s_ready=0).
//    rx_ack->0 -> IDLE after 2 more edges.
//  4 Change s_data to 8'h3C while in WAIT_ACK -> tx_data stays A5 until completion.
//  5 Assert rst_src while in WAIT_ACK -> tx_req=0, tx_data=0, done never pulses.
//  6 CDC_TX_BUF_EN: send 8'h11 then 8'h22 back-to-back -> second accepted while first in flight.
//    22 launched on the edge 11 completes; two done pulses; tx_req toggles twice in total.

Source files
------------

// File: rtl/cdc_hs_tx_pkg.sv
// rtl/cdc_hs_tx_pkg.sv - shared state encoding and synchronizer depth limits for the toggle handshake
package cdc_hs_tx_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } state_t;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 4;

  // Wide enough to count up to SYNC_STAGES_MAX-1 settle edges.
  localparam int SETTLE_CNT_W = 2;

endpackage

// File: rtl/cdc_sync_dff.sv
// rtl/cdc_sync_dff.sv - multi-stage flop synchronizer into the clk_dest domain (flops are not reset)
module cdc_sync_dff #(
  parameter int DATA_WIDTH      = 1,
  parameter int NUM_SYNC_STAGES = 2
) (
  input  logic                  clk_dest,
  input  logic [DATA_WIDTH-1:0] async_in,
  output logic [DATA_WIDTH-1:0] sync_out
);

  logic [DATA_WIDTH-1:0] stages [NUM_SYNC_STAGES];

  // Shift the asynchronous input through the synchronizer chain.
  always_ff @(posedge clk_dest) begin
    stages[0] <= async_in;
    for (int i = 1; i < NUM_SYNC_STAGES; i++) begin
      stages[i] <= stages[i-1];
    end
  end

  assign sync_out = stages[NUM_SYNC_STAGES-1];

endmodule

// File: rtl/cdc_hs_tx.sv
// rtl/cdc_hs_tx.sv - source side of a 2-phase req/ack word handshake; optional CDC_TX_BUF_EN adds a one-entry holding buffer
module cdc_hs_tx
  import cdc_hs_tx_pkg::*;
#(
  parameter int DATA_WIDTH      = 8,
  parameter int NUM_SYNC_STAGES = 2
) (
  input  logic                  clk_src,
  input  logic                  rst_src,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_req,
  input  logic                  rx_ack,
  output logic                  busy,
  output logic                  done
);

  if (NUM_SYNC_STAGES < SYNC_STAGES_MIN || NUM_SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
    $error("cdc_hs_tx: NUM_SYNC_STAGES must be within 2..4");
  end

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(NUM_SYNC_STAGES - 1);

  state_t                  state_q;
  state_t                  state_d;
  logic                    ack_sync;
  logic                    ack_match;
  logic [SETTLE_CNT_W-1:0] settle_cnt;
  logic                    settled;
  logic                    launch;
  logic [DATA_WIDTH-1:0]   launch_data;
  logic                    complete;

`ifdef CDC_TX_BUF_EN
  logic                    buf_valid;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    buf_load;
  logic                    buf_clear;
`endif

  cdc_sync_dff #(
    .DATA_WIDTH      (1),
    .NUM_SYNC_STAGES (NUM_SYNC_STAGES)
  ) u_ack_sync (
    .clk_dest (clk_src),
    .async_in (rx_ack),
    .sync_out (ack_sync)
  );

  // Handshake is complete whenever the returned ack has caught up with our request toggle.
  assign ack_match = (ack_sync == tx_req);
  assign settled   = (settle_cnt == SETTLE_LAST);
  assign busy      = (state_q != IDLE);

  // State register.
  always_ff @(posedge clk_src) begin
    if (rst_src) state_q <= INIT;
    else         state_q <= state_d;
  end

  // Let the ack synchronizer flush before trusting its output after reset.
  always_ff @(posedge clk_src) begin
    if (rst_src)                          settle_cnt <= '0;
    else if (state_q == INIT && !settled) settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
  end

  // Next-state, ready and launch decisions.
  always_comb begin
    state_d     = state_q;
    s_ready     = 1'b0;
    launch      = 1'b0;
    launch_data = s_data;
    complete    = 1'b0;
`ifdef CDC_TX_BUF_EN
    buf_load    = 1'b0;
    buf_clear   = 1'b0;
`endif
    case (state_q)
      INIT: begin
        // A mismatch here means the destination still holds a stale ack toggle.
        if (settled && ack_match) state_d = IDLE;
      end
      IDLE: begin
        s_ready = 1'b1;
        if (s_valid) begin
          launch  = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
`ifdef CDC_TX_BUF_EN
        s_ready = !buf_valid;
        if (ack_match) begin
          complete = 1'b1;
          if (buf_valid) begin
            launch      = 1'b1;
            launch_data = buf_data;
            buf_clear   = 1'b1;
          end else if (s_valid) begin
            launch = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (s_valid && !buf_valid) begin
          buf_load = 1'b1;
        end
`else
        if (ack_match) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
`endif
      end
      default: state_d = INIT;
    endcase
  end

  // Outgoing word and request toggle; only updated on a launch so tx_data is stable in flight.
  always_ff @(posedge clk_src) begin
    if (rst_src) begin
      tx_req  <= 1'b0;
      tx_data <= '0;
      done    <= 1'b0;
    end else begin
      done <= complete;
      if (launch) begin
        tx_data <= launch_data;
        tx_req  <= ~tx_req;
      end
    end
  end

`ifdef CDC_TX_BUF_EN
  // Holding buffer for one word accepted while the previous one is still in flight.
  always_ff @(posedge clk_src) begin
    if (rst_src) begin
      buf_valid <= 1'b0;
      buf_data  <= '0;
    end else if (buf_load) begin
      buf_valid <= 1'b1;
      buf_data  <= s_data;
    end else if (buf_clear) begin
      buf_valid <= 1'b0;
    end
  end
`endif

  // An ack toggle arriving while idle means the destination broke the protocol.
  spurious_ack_in_idle: assert property (
    @(posedge clk_src) disable iff (rst_src) (state_q == IDLE) |-> ack_match
  );

endmodule

// File: tb/tb_cdc_hs_tx.sv
// tb/tb_cdc_hs_tx.sv - self-checking bench for cdc_hs_tx with a synchronizer-based receiver model
module tb_cdc_hs_tx;

  logic       clk_src = 1'b0;
  logic       clk_dest = 1'b0;
  logic       rst_src;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       rx_ack;
  logic       busy;
  logic       done;

  logic       auto_ack;
  logic       man_ack;
  logic       dst_ack;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk_src  = ~clk_src;
  always #7 clk_dest = ~clk_dest;

  cdc_hs_tx #(
    .DATA_WIDTH      (8),
    .NUM_SYNC_STAGES (2)
  ) dut (
    .clk_src (clk_src),
    .rst_src (rst_src),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .rx_ack  (rx_ack),
    .busy    (busy),
    .done    (done)
  );

  // Receiver model: destination synchronizes tx_req and echoes it back as the ack toggle.
  cdc_sync_dff #(
    .DATA_WIDTH      (1),
    .NUM_SYNC_STAGES (2)
  ) u_rx_model (
    .clk_dest (clk_dest),
    .async_in (tx_req),
    .sync_out (dst_ack)
  );

  assign rx_ack = auto_ack ? dst_ack : man_ack;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Transaction-level scoreboard: every accepted word must come out, in order, on a req toggle.
  logic       mon_en = 1'b0;
  logic       prev_req;
  logic [7:0] prev_data;
  logic [7:0] accepted_q[$];
  int         launches;
  int         dones;

  always @(negedge clk_src) begin
    if (mon_en) begin
      if (tx_req !== prev_req) begin
        launches++;
        compared++;
        if (accepted_q.size() == 0) begin
          mismatched++;
          $display("FAIL launch_without_accept: got tx_data %0h expected no launch", tx_data);
        end else begin
          if (tx_data !== accepted_q[0]) begin
            mismatched++;
            $display("FAIL launch_data: got %0h expected %0h", tx_data, accepted_q[0]);
          end
          void'(accepted_q.pop_front());
        end
      end else if (tx_data !== prev_data) begin
        compared++;
        mismatched++;
        $display("FAIL tx_data_stable: got %0h expected %0h", tx_data, prev_data);
      end
      if (done) dones++;
      if (s_valid && s_ready) accepted_q.push_back(s_data);
      prev_req  = tx_req;
      prev_data = tx_data;
    end
  end

  typedef struct {
    logic       s_valid;
    logic [7:0] s_data;
    logic       ack;
    logic       exp_ready;
    logic       exp_busy;
    logic       exp_done;
    logic       exp_req;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs[13];

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk_src);
      n++;
    end
    check(name, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic       exp_ready;
    logic       seen22;
    logic       done_at_22;

    rst_src  = 1'b1;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    auto_ack = 1'b0;
    man_ack  = 1'b0;

    // Cycle-by-cycle expectations after reset release; manual ack.
    vecs[0]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[3]  = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[4]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[5]  = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'hA5};
    vecs[6]  = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'hA5};
    vecs[7]  = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hA5};
    vecs[8]  = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[9]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[10] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h5A};
    vecs[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h5A};
    vecs[12] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h5A};

    repeat (5) @(posedge clk_src);
    @(negedge clk_src);
    check("reset_ready", {31'd0, s_ready}, 32'd0);
    check("reset_busy",  {31'd0, busy},    32'd1);
    check("reset_done",  {31'd0, done},    32'd0);
    check("reset_req",   {31'd0, tx_req},  32'd0);
    check("reset_data",  {24'd0, tx_data}, 32'd0);
    rst_src = 1'b0;

    for (int i = 0; i < 13; i++) begin
      s_valid = vecs[i].s_valid;
      s_data  = vecs[i].s_data;
      man_ack = vecs[i].ack;
      @(posedge clk_src);
      @(negedge clk_src);
      exp_ready = vecs[i].exp_ready;
`ifdef CDC_TX_BUF_EN
      // With the buffer empty, WAIT_ACK also reports ready.
      if (i != 0 && vecs[i].exp_busy) exp_ready = 1'b1;
`endif
      check($sformatf("vec%0d_ready", i), {31'd0, s_ready}, {31'd0, exp_ready});
      check($sformatf("vec%0d_busy", i),  {31'd0, busy},    {31'd0, vecs[i].exp_busy});
      check($sformatf("vec%0d_done", i),  {31'd0, done},    {31'd0, vecs[i].exp_done});
      check($sformatf("vec%0d_req", i),   {31'd0, tx_req},  {31'd0, vecs[i].exp_req});
      check($sformatf("vec%0d_data", i),  {24'd0, tx_data}, {24'd0, vecs[i].exp_data});
    end
    s_valid = 1'b0;

    // Stale ack held high through reset keeps the block in INIT.
    man_ack = 1'b1;
    rst_src = 1'b1;
    repeat (4) @(posedge clk_src);
    @(negedge clk_src);
    rst_src = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk_src);
      @(negedge clk_src);
      check($sformatf("stale_ack_ready%0d", i), {31'd0, s_ready}, 32'd0);
      check($sformatf("stale_ack_busy%0d", i),  {31'd0, busy},    32'd1);
    end
    man_ack = 1'b0;
    @(posedge clk_src);
    @(negedge clk_src);
    @(posedge clk_src);
    @(negedge clk_src);
    check("stale_clear_k1_ready", {31'd0, s_ready}, 32'd0);
    @(posedge clk_src);
    @(negedge clk_src);
    check("stale_clear_k2_ready", {31'd0, s_ready}, 32'd1);
    check("stale_clear_k2_busy",  {31'd0, busy},    32'd0);

    // Reset during WAIT_ACK drops the transfer.
    s_valid = 1'b1;
    s_data  = 8'h77;
    @(posedge clk_src);
    @(negedge clk_src);
    s_valid = 1'b0;
    check("midrst_launch_req",  {31'd0, tx_req},  32'd1);
    check("midrst_launch_data", {24'd0, tx_data}, 32'h77);
    rst_src = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_src);
      @(negedge clk_src);
      check($sformatf("midrst_req%0d", i),  {31'd0, tx_req},  32'd0);
      check($sformatf("midrst_data%0d", i), {24'd0, tx_data}, 32'd0);
      check($sformatf("midrst_done%0d", i), {31'd0, done},    32'd0);
    end
    rst_src = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_src);
      @(negedge clk_src);
      check($sformatf("midrst_post_done%0d", i), {31'd0, done}, 32'd0);
    end
    check("midrst_reinit_ready", {31'd0, s_ready}, 32'd1);

    // Randomized traffic against the echoing receiver model.
    auto_ack = 1'b1;
    repeat (6) @(posedge clk_src);
    #1;
    prev_req  = tx_req;
    prev_data = tx_data;
    accepted_q.delete();
    launches = 0;
    dones    = 0;
    mon_en   = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk_src);
      #1;
      s_valid = 1'($urandom_range(0, 1));
      s_data  = 8'($urandom);
    end
    @(posedge clk_src);
    #1;
    s_valid = 1'b0;
    @(negedge clk_src);
    wait_idle("rand_drain_idle", 300);
    repeat (2) @(negedge clk_src);
    check("rand_queue_empty", accepted_q.size(), 32'd0);
    check("rand_done_vs_launch", dones, launches);
    check("rand_some_traffic", {31'd0, launches > 20}, 32'd1);

`ifdef CDC_TX_BUF_EN
    // Back-to-back words: second goes into the buffer and launches on the first's completion edge.
    @(posedge clk_src);
    #1;
    launches = 0;
    dones    = 0;
    s_valid  = 1'b1;
    s_data   = 8'h11;
    @(posedge clk_src);
    #1;
    s_data = 8'h22;
    @(negedge clk_src);
    check("buf_second_ready", {31'd0, s_ready}, 32'd1);
    @(posedge clk_src);
    #1;
    s_valid = 1'b0;
    @(negedge clk_src);
    check("buf_full_ready", {31'd0, s_ready}, 32'd0);
    check("buf_first_data", {24'd0, tx_data}, 32'h11);
    seen22     = 1'b0;
    done_at_22 = 1'b0;
    for (int n = 0; n < 100 && busy !== 1'b0; n++) begin
      @(negedge clk_src);
      if (!seen22 && tx_data == 8'h22) begin
        seen22     = 1'b1;
        done_at_22 = done;
      end
    end
    check("buf_drain_idle",   {31'd0, busy},       32'd0);
    check("buf_22_launched",  {31'd0, seen22},     32'd1);
    check("buf_22_with_done", {31'd0, done_at_22}, 32'd1);
    repeat (2) @(negedge clk_src);
    check("buf_two_toggles", launches, 32'd2);
    check("buf_two_dones",   dones,    32'd2);
`endif

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
